// File: rtl/line_setup_sub_if.sv
// Endpoint-in / setup-out bundle between the line source, the setup
// front end and the Bresenham stepper.
interface line_setup_sub_if #(
  parameter int WIDTH = 13
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] x1;
  logic signed [WIDTH-1:0] y1;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] dx;
  logic signed [WIDTH-1:0] dy;
  logic                    step_x;
  logic                    step_y;
  logic                    steep;
  logic        [WIDTH-1:0] major;
  logic        [WIDTH-1:0] minor;
  logic signed [WIDTH+1:0] err0;
  logic        [WIDTH:0]   npix;
  logic                    ovf;

  modport slave (
    input  in_valid, x0, y0, x1, y1, out_ready,
    output in_ready, out_valid, dx, dy, step_x, step_y, steep,
           major, minor, err0, npix, ovf
  );

  modport master (
    output in_valid, x0, y0, x1, y1, out_ready,
    input  in_ready, out_valid, dx, dy, step_x, step_y, steep,
           major, minor, err0, npix, ovf
  );
endinterface

// File: rtl/line_setup_sub.sv
// Line setup front end: two-stage pipeline turning endpoint pairs into the
// folded deltas, octant info, initial error term and pixel count for the stepper.
module line_setup_sub #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  line_setup_sub_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

  // stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_dx;
  logic [WIDTH-1:0] s1_dy;
  logic             s1_ovf;

  // stage 2 registers (drive the outputs directly)
  logic             s2_valid;
  logic [WIDTH-1:0] s2_dx;
  logic [WIDTH-1:0] s2_dy;
  logic             s2_step_x;
  logic             s2_step_y;
  logic             s2_steep;
  logic [WIDTH-1:0] s2_major;
  logic [WIDTH-1:0] s2_minor;
  logic [WIDTH+1:0] s2_err0;
  logic [WIDTH:0]   s2_npix;
  logic             s2_ovf;

  logic adv1;
  logic adv2;

  assign adv2        = ~s2_valid | bus.out_ready;
  assign adv1        = ~s1_valid | adv2;
  assign bus.in_ready = adv1;

  // Full-precision differences; the bit below the sign is dropped on fold.
  logic [WIDTH:0]   dx_full;
  logic [WIDTH:0]   dy_full;
  logic [WIDTH-1:0] dx_fold;
  logic [WIDTH-1:0] dy_fold;
  logic             ovf_c;

  always_comb begin
    dx_full = {bus.x1[WIDTH-1], bus.x1} - {bus.x0[WIDTH-1], bus.x0};
    dy_full = {bus.y1[WIDTH-1], bus.y1} - {bus.y0[WIDTH-1], bus.y0};
    dx_fold = {dx_full[WIDTH], dx_full[WIDTH-2:0]};
    dy_fold = {dy_full[WIDTH], dy_full[WIDTH-2:0]};
    ovf_c   = (dx_full[WIDTH] != dx_full[WIDTH-1]) |
              (dy_full[WIDTH] != dy_full[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_ovf   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_dx  <= dx_fold;
        s1_dy  <= dy_fold;
        s1_ovf <= ovf_c;
      end
    end
  end

  // Magnitudes are unsigned, so the most-negative delta maps to 2^(WIDTH-1).
  logic [WIDTH-1:0] abs_dx;
  logic [WIDTH-1:0] abs_dy;
  logic             steep_c;
  logic [WIDTH-1:0] major_c;
  logic [WIDTH-1:0] minor_c;
  logic [WIDTH+1:0] err0_c;
  logic [WIDTH:0]   npix_c;

  always_comb begin
    abs_dx  = s1_dx[WIDTH-1] ? (~s1_dx + ONE_W) : s1_dx;
    abs_dy  = s1_dy[WIDTH-1] ? (~s1_dy + ONE_W) : s1_dy;
    steep_c = abs_dy > abs_dx;
    major_c = steep_c ? abs_dy : abs_dx;
    minor_c = steep_c ? abs_dx : abs_dy;
    err0_c  = {1'b0, minor_c, 1'b0} - {2'b00, major_c};
    npix_c  = {1'b0, major_c} + ONE_W1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_dx     <= '0;
      s2_dy     <= '0;
      s2_step_x <= 1'b0;
      s2_step_y <= 1'b0;
      s2_steep  <= 1'b0;
      s2_major  <= '0;
      s2_minor  <= '0;
      s2_err0   <= '0;
      s2_npix   <= '0;
      s2_ovf    <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dx     <= s1_dx;
        s2_dy     <= s1_dy;
        s2_step_x <= s1_dx[WIDTH-1];
        s2_step_y <= s1_dy[WIDTH-1];
        s2_steep  <= steep_c;
        s2_major  <= major_c;
        s2_minor  <= minor_c;
        s2_err0   <= err0_c;
        s2_npix   <= npix_c;
        s2_ovf    <= s1_ovf;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.dx        = s2_dx;
  assign bus.dy        = s2_dy;
  assign bus.step_x    = s2_step_x;
  assign bus.step_y    = s2_step_y;
  assign bus.steep     = s2_steep;
  assign bus.major     = s2_major;
  assign bus.minor     = s2_minor;
  assign bus.err0      = s2_err0;
  assign bus.npix      = s2_npix;
  assign bus.ovf       = s2_ovf;

endmodule

// File: tb/tb_line_setup_sub.sv
// Directed-vector bench for line_setup_sub: per-line latency, streaming,
// backpressure ordering and asynchronous reset with lines in flight.
module tb_line_setup_sub;
  localparam int W = 13;
  localparam int NV = 8;

  logic clk;
  logic rst_n;

  line_setup_sub_if #(.WIDTH(W)) bus ();

  line_setup_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, x1, y1;
    int dx, dy, sx, sy, steep, major, minor, err0, npix, ovf;
  } vec_t;

  vec_t vt[NV];
  int n_vec;
  int n_miss;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    bus.x0 = W'(vt[i].x0);
    bus.y0 = W'(vt[i].y0);
    bus.x1 = W'(vt[i].x1);
    bus.y1 = W'(vt[i].y1);
  endtask

  task automatic check_res(input int i, input string tag);
    chk($sformatf("%s[%0d].dx", tag, i),     bus.dx,     vt[i].dx);
    chk($sformatf("%s[%0d].dy", tag, i),     bus.dy,     vt[i].dy);
    chk($sformatf("%s[%0d].step_x", tag, i), bus.step_x, vt[i].sx);
    chk($sformatf("%s[%0d].step_y", tag, i), bus.step_y, vt[i].sy);
    chk($sformatf("%s[%0d].steep", tag, i),  bus.steep,  vt[i].steep);
    chk($sformatf("%s[%0d].major", tag, i),  bus.major,  vt[i].major);
    chk($sformatf("%s[%0d].minor", tag, i),  bus.minor,  vt[i].minor);
    chk($sformatf("%s[%0d].err0", tag, i),   bus.err0,   vt[i].err0);
    chk($sformatf("%s[%0d].npix", tag, i),   bus.npix,   vt[i].npix);
    chk($sformatf("%s[%0d].ovf", tag, i),    bus.ovf,    vt[i].ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One line through an idle pipe with out_ready high: visible exactly 2 cycles later.
  task automatic single(input int i, input string tag);
    bus.out_ready = 1'b1;
    drive(i);
    bus.in_valid = 1'b1;
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".lat1_valid"}, bus.out_valid, 0);
    tick();
    chk({tag, ".lat2_valid"}, bus.out_valid, 1);
    check_res(i, tag);
    tick();
    chk({tag, ".drained"}, bus.out_valid, 0);
  endtask

  initial begin
    //          x0     y0   x1     y1     dx     dy  sx sy st  major minor  err0  npix ovf
    vt[0] = '{   10,   20,   30,    25,    20,     5, 0, 0, 0,   20,    5,   -10,   21, 0};
    vt[1] = '{  100,   50,   90,    10,   -10,   -40, 1, 1, 1,   40,   10,   -20,   41, 0};
    vt[2] = '{-3000,    0, 2000,     0,   904,     0, 0, 0, 0,  904,    0,  -904,  905, 1};
    vt[3] = '{    7,    7,    7,     7,     0,     0, 0, 0, 0,    0,    0,     0,    1, 0};
    vt[4] = '{    0,    0,  -15,    15,   -15,    15, 1, 0, 0,   15,   15,    15,   16, 0};
    vt[5] = '{    0,    0,-4096,     0, -4096,     0, 1, 0, 0, 4096,    0, -4096, 4097, 0};
    vt[6] = '{    0, 4095,    3, -4096,     3, -4095, 0, 1, 1, 4095,    3, -4089, 4096, 1};
    vt[7] = '{    5,   -5,   -2,     9,    -7,    14, 1, 0, 1,   14,    7,     0,   15, 0};

    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.x1 = '0;
    bus.y1 = '0;

    repeat (3) tick();
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.in_ready",  bus.in_ready,  1);
    chk("rst.dx",        bus.dx,        0);
    chk("rst.err0",      bus.err0,      0);
    chk("rst.npix",      bus.npix,      0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) single(i, "single");

    // Back-to-back stream: inputs presented at cycle c show up at cycle c+2.
    bus.out_ready = 1'b1;
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        drive(c);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      chk("stream.in_ready", bus.in_ready, 1);
      if (c >= 2) begin
        chk("stream.out_valid", bus.out_valid, 1);
        check_res(c - 2, "stream");
      end else begin
        chk("stream.out_valid", bus.out_valid, 0);
      end
      tick();
    end
    chk("stream.drained", bus.out_valid, 0);

    // Backpressure: lines 0,1 fill the pipe, line 4 waits for out_ready.
    bus.out_ready = 1'b0;
    drive(0);
    bus.in_valid = 1'b1;
    chk("bp.ready_a", bus.in_ready, 1);
    tick();
    drive(1);
    chk("bp.ready_b", bus.in_ready, 1);
    tick();
    drive(4);
    for (int k = 0; k < 3; k++) begin
      chk("bp.full_in_ready", bus.in_ready, 0);
      chk("bp.full_out_valid", bus.out_valid, 1);
      check_res(0, "bp.hold");
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.ready_release", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp.out1_valid", bus.out_valid, 1);
    check_res(1, "bp.out1");
    tick();
    chk("bp.out2_valid", bus.out_valid, 1);
    check_res(4, "bp.out2");
    tick();
    chk("bp.drained", bus.out_valid, 0);

    // Async reset with two lines in flight.
    bus.out_ready = 1'b0;
    drive(1);
    bus.in_valid = 1'b1;
    tick();
    drive(7);
    tick();
    bus.in_valid = 1'b0;
    chk("arst.pre_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", bus.out_valid, 0);
    chk("arst.in_ready",  bus.in_ready,  1);
    chk("arst.dx",        bus.dx,        0);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    tick();
    chk("arst.no_stale", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("arst.no_stale2", bus.out_valid, 0);
    single(6, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
